// File: rtl/or_reduce_arb.sv
// or_reduce_arb: round-robin front end for a shared D-bit OR accumulator.
// The granted requester streams N words over valid/ready. The block ORs
// them into an accumulator and presents the result tagged with the owner id.
module or_reduce_arb #(
    parameter int R = 4,
    parameter int N = 4,
    parameter int D = 16
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [R-1:0]                        i_req,
    output logic [R-1:0]                        o_gnt,
    input  logic [R-1:0]                        i_valid,
    input  logic [D-1:0]                        i_data [R-1:0],
    output logic [R-1:0]                        o_ready,
    output logic [D-1:0]                        o_result,
    output logic                                o_result_valid,
    output logic [((R > 1) ? $clog2(R) : 1)-1:0] o_result_id,
    input  logic                                i_result_ready,
    output logic                                o_busy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (N > 1) ? $clog2(N + 1) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
    localparam logic [R-1:0]  ONE_HOT0  = R'(1);

    logic [1:0]    state;
    logic [R-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] ptr;
    logic [D-1:0]  acc;
    logic [D-1:0]  result;
    logic          result_valid;
    logic [CW-1:0] count;

    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand;
    logic [IW-1:0] next_ptr;
    logic [D-1:0]  beat_data;

    // (base + off) mod R without relying on R being a power of two
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= R) s = s - R;
        return IW'(s);
    endfunction

    // Pick the first active request at or above ptr, wrapping to 0
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < R; k++) begin
            cand = wrap_add(ptr, k);
            if (!sel_found && i_req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Pointer moves past the owner when its job finishes or aborts
    always_comb begin
        next_ptr  = wrap_add(grant_id, 1);
        beat_data = i_data[grant_id];
    end

    // Main sequencer: grant, accumulate beats, hold result until consumed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            grant_id     <= '0;
            ptr          <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant    <= ONE_HOT0 << sel_idx;
                        grant_id <= sel_idx;
                        acc      <= '0;
                        count    <= '0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    // A dropped request wins over a beat in the same cycle
                    if (!i_req[grant_id]) begin
                        grant <= '0;
                        ptr   <= next_ptr;
                        acc   <= '0;
                        count <= '0;
                        state <= IDLE;
                    end else if (i_valid[grant_id]) begin
                        if (count == LAST_BEAT) begin
                            result       <= acc | beat_data;
                            result_valid <= 1'b1;
                            count        <= '0;
                            state        <= RESULT;
                        end else begin
                            acc   <= acc | beat_data;
                            count <= count + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (i_result_ready) begin
                        result_valid <= 1'b0;
                        grant        <= '0;
                        ptr          <= next_ptr;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from registered state; no path from i_valid
    always_comb begin
        o_gnt          = grant;
        o_ready        = (state == ACCUM) ? grant : '0;
        o_result       = result;
        o_result_valid = result_valid;
        o_result_id    = grant_id;
        o_busy         = (state != IDLE);
    end

endmodule

// File: tb/tb_or_reduce_arb.sv
// Directed bench for or_reduce_arb: expected results go into a scoreboard
// queue as jobs are issued; a monitor pops them on each result handshake.
module tb_or_reduce_arb;

    localparam int R = 4;
    localparam int N = 4;
    localparam int D = 16;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic          i_clk;
    logic          i_rst_n;
    logic [R-1:0]  i_req;
    logic [R-1:0]  o_gnt;
    logic [R-1:0]  i_valid;
    logic [D-1:0]  i_data [R-1:0];
    logic [R-1:0]  o_ready;
    logic [D-1:0]  o_result;
    logic          o_result_valid;
    logic [1:0]    o_result_id;
    logic          i_result_ready;
    logic          o_busy;

    int   checks;
    int   failures;
    exp_t exp_q [$];

    or_reduce_arb #(.R(R), .N(N), .D(D)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_req          (i_req),
        .o_gnt          (o_gnt),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_result       (o_result),
        .o_result_valid (o_result_valid),
        .o_result_id    (o_result_id),
        .i_result_ready (i_result_ready),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input int g, input logic [15:0] d);
        i_valid[g] = 1'b1;
        i_data[g]  = d;
        tick();
        i_valid[g] = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n        = 1'b0;
        i_req          = '0;
        i_valid        = '0;
        i_result_ready = 1'b1;
        for (int k = 0; k < R; k++) i_data[k] = '0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    // Scoreboard monitor and invariant checks
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            chk("gnt_onehot", 32'((o_gnt & (o_gnt - 1'b1)) == '0), 32'd1);
            chk("ready_subset", 32'((o_ready & ~o_gnt) == '0), 32'd1);
            if (o_result_valid && i_result_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(o_result), 32'(e.data));
                    chk("sb_id", 32'(o_result_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // Reset values
        do_reset();
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_result", 32'(o_result), 32'd0);
        chk("rst_rvalid", 32'(o_result_valid), 32'd0);
        chk("rst_id", 32'(o_result_id), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);

        // 1: single requester, four distinct words
        i_req = 4'b0010;
        tick();
        chk("t1_gnt", 32'(o_gnt), 32'h2);
        exp_q.push_back('{id: 2'd1, data: 16'h1111});
        beat(1, 16'h0001);
        beat(1, 16'h0010);
        beat(1, 16'h0100);
        chk("t1_not_yet", 32'(o_result_valid), 32'd0);
        beat(1, 16'h1000);
        chk("t1_rvalid", 32'(o_result_valid), 32'd1);
        chk("t1_result", 32'(o_result), 32'h1111);
        chk("t1_id", 32'(o_result_id), 32'd1);
        i_req = '0;
        tick();
        chk("t1_idle", 32'(o_busy), 32'd0);

        // 2: all requesting, round-robin order 0,1,2,3,0
        do_reset();
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            int e;
            e = j % R;
            tick();
            chk("t2_gnt", 32'(o_gnt), 32'(1) << e);
            exp_q.push_back('{id: 2'(e), data: 16'h8000});
            for (int b = 0; b < N; b++) beat(e, 16'h8000);
            chk("t2_rvalid", 32'(o_result_valid), 32'd1);
            tick();
            chk("t2_idle_gap", 32'(o_gnt), 32'd0);
        end

        // 3: result back-pressure holds everything stable
        do_reset();
        i_req          = 4'b0101;
        i_result_ready = 1'b0;
        tick();
        chk("t3_gnt0", 32'(o_gnt), 32'h1);
        exp_q.push_back('{id: 2'd0, data: 16'h000F});
        beat(0, 16'h0001);
        beat(0, 16'h0002);
        beat(0, 16'h0004);
        beat(0, 16'h0008);
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(o_result_valid), 32'd1);
            chk("t3_hold_result", 32'(o_result), 32'h000F);
            chk("t3_hold_id", 32'(o_result_id), 32'd0);
            chk("t3_hold_gnt", 32'(o_gnt), 32'h1);
            tick();
        end
        i_result_ready = 1'b1;
        i_req          = 4'b0100;
        tick();
        chk("t3_idle", 32'(o_gnt), 32'd0);
        tick();
        chk("t3_gnt2", 32'(o_gnt), 32'h4);

        // 4: non-granted requester noise and valid gaps
        do_reset();
        i_req = 4'b0001;
        tick();
        chk("t4_gnt", 32'(o_gnt), 32'h1);
        i_valid[2] = 1'b1;
        i_data[2]  = 16'hFFFF;
        exp_q.push_back('{id: 2'd0, data: 16'h0003});
        for (int b = 0; b < N; b++) begin
            chk("t4_ready", 32'(o_ready), 32'h1);
            beat(0, 16'h0003);
            if (b < N - 1) begin
                for (int g = 0; g < 2; g++) begin
                    chk("t4_gap_rvalid", 32'(o_result_valid), 32'd0);
                    chk("t4_gap_ready", 32'(o_ready), 32'h1);
                    tick();
                end
            end
        end
        chk("t4_rvalid", 32'(o_result_valid), 32'd1);
        chk("t4_result", 32'(o_result), 32'h0003);
        i_valid = '0;
        i_req   = '0;
        tick();

        // 5: abort after two beats, beat in the abort cycle is dropped
        do_reset();
        i_req = 4'b1000;
        tick();
        chk("t5_gnt3", 32'(o_gnt), 32'h8);
        i_req = 4'b1001;
        beat(3, 16'h00F0);
        beat(3, 16'h0F00);
        i_req      = 4'b0001;
        i_valid[3] = 1'b1;
        i_data[3]  = 16'hF000;
        tick();
        i_valid = '0;
        chk("t5_abort_gnt", 32'(o_gnt), 32'd0);
        chk("t5_abort_busy", 32'(o_busy), 32'd0);
        chk("t5_abort_rvalid", 32'(o_result_valid), 32'd0);
        tick();
        chk("t5_gnt0", 32'(o_gnt), 32'h1);

        // 6: asynchronous reset mid-job
        do_reset();
        i_req = 4'b0001;
        tick();
        i_valid[0] = 1'b1;
        i_data[0]  = 16'h00AA;
        tick();
        chk("t6_pre_busy", 32'(o_busy), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(o_gnt), 32'd0);
        chk("t6_rst_ready", 32'(o_ready), 32'd0);
        chk("t6_rst_rvalid", 32'(o_result_valid), 32'd0);
        chk("t6_rst_busy", 32'(o_busy), 32'd0);
        i_valid = '0;
        i_req   = 4'b1010;
        tick();
        i_rst_n = 1'b1;
        tick();
        chk("t6_gnt1", 32'(o_gnt), 32'h2);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/or_reduce_arb.md
Name: or_reduce_arb

Overview:
- Round-robin controller that shares one D-bit OR accumulator datapath between R requesters.
- A granted requester streams N operand words over a valid/ready handshake. The block ORs them into the accumulator and returns the D-bit result with the requester's id.
- Sits between client units and the OR reduction datapath (or_np / not_nb / and_np family). It sequences multi-word reductions and serialises access to the datapath.

Parameters:
- R, 4, number of requesters (>=2).
- N, 4, operand words per job (>=1).
- D, 16, operand and result bit width.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  R  per-requester job request, level; held for the whole job.
- o_gnt  output  R  one-hot grant; all-zero when no job is active.
- i_valid  input  R  per-requester operand valid.
- i_data  input  D x R  per-requester operand words (unpacked array [R-1:0]).
- o_ready  output  R  operand ready; at most the granted bit is set.
- o_result  output  D  OR of all N accepted words of the job.
- o_result_valid  output  1  result available.
- o_result_id  output  clog2(R)  index of the requester owning o_result.
- i_result_ready  input  1  result consumer accepts.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low. Assertion immediately forces:
  - state=IDLE, o_gnt=0, o_ready=0
  - o_result=0, o_result_valid=0, o_result_id=0
  - acc=0, beat count=0, round-robin pointer=0
  Reset mid-job discards the job with no result. Release is synchronous to i_clk.
- State machine: IDLE, ACCUM, RESULT.
- IDLE:
  - If i_req != 0, select the first set bit searching upward from ptr, wrapping R-1 -> 0.
  - Register o_gnt (one-hot), o_result_id, acc=0, count=0; go to ACCUM.
  - Grant appears exactly 1 cycle after i_req is sampled. If i_req==0, stay in IDLE.
- ACCUM:
  - o_ready = o_gnt (driven from registered state; no combinational path from i_valid).
  - A beat is accepted when i_valid[g] && o_ready[g]: acc <= acc | i_data[g]; count++.
  - i_valid and i_data of non-granted requesters are ignored.
  - Gaps (i_valid[g]=0) stall without state change.
  - On acceptance of beat N-1: o_result <= acc | i_data[g]; go to RESULT.
  - N=1: the first accepted beat goes directly to RESULT.
- Abort:
  - If i_req[g] is low in any ACCUM cycle, go to IDLE: o_gnt=0, no result, ptr <= (g+1) mod R.
  - Abort takes priority over a same-cycle beat; that beat is not accepted.
- RESULT:
  - o_result_valid=1; o_result and o_result_id are stable; o_gnt held; o_ready=0.
  - Requests from others wait.
  - On i_result_ready: next cycle go to IDLE, o_result_valid=0, o_gnt=0, ptr <= (g+1) mod R.
  - o_result keeps its last value until the next job's result loads.
  - i_req changes during RESULT are ignored.
- Fairness: a requester holding i_req continuously waits at most R-1 jobs.
- Minimum job latency: i_req to o_result_valid is N+1 cycles with no valid gaps. Back-to-back jobs have 1 IDLE cycle between RESULT and the next grant.
- Width rules:
  - count is clog2(N+1) bits and never exceeds N-1 while in ACCUM.
  - ptr wraps modulo R; this covers non-power-of-2 R.
- Invariants:
  - o_gnt is zero or one-hot.
  - o_ready is a subset of o_gnt.
  - o_result_valid implies state==RESULT.

Test Plan:
1. R=4,N=4: only i_req[1]=1, data 0x0001,0x0010,0x0100,0x1000 on consecutive cycles -> o_gnt=4'b0010 one cycle after req; o_result=0x1111, o_result_id=1, valid in the cycle after the 4th beat.
2. i_req=4'b1111 held, all data 0x8000, i_result_ready=1 -> grant order 0,1,2,3,0; each result 0x8000 with matching id; one IDLE cycle between jobs.
3. Requester 0 job completes; i_result_ready held low 5 cycles -> o_result, o_result_id and o_result_valid stable; o_gnt held; no new grant despite i_req[2]=1; grant to 2 follows release.
4. Requester 0 granted; requester 2 drives i_valid=1, data 0xFFFF every cycle; requester 0 sends 0x0003 with 2-cycle valid gaps -> o_ready[2]=0 throughout; result 0x0003; job length extended by the gaps only.
5. Requester 3 granted; drops i_req after 2 beats while i_req[0]=1 -> IDLE next cycle; no o_result_valid; next grant 4'b0001 (ptr wrapped to 0).
6. i_rst_n pulsed low mid-ACCUM (asynchronously, between edges) -> o_gnt, o_ready, o_result_valid and o_busy go 0 before the next edge. After release with i_req=4'b1010, first grant goes to requester 1.
